// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: turns field-level requests into 32-bit machine words
// and streams them into instruction memory at an auto-incrementing address.
module legv8_instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rn,
    input  logic [4:0]        req_rm,
    input  logic [31:0]       req_imm,
    input  logic [1:0]        req_hw,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              err,
    output logic [15:0]       instr_cnt
);

    typedef enum logic [1:0] {IDLE, ENC, WRITE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  op_q, rd_q, rn_q, rm_q;
    logic [31:0] imm_q;
    logic [1:0]  hw_q;
    logic [31:0] enc_word;
    logic        enc_ok;

    // Signed fields fit when every bit above the field's sign bit matches it.
    function automatic logic fits_signed(input logic [31:0] v, input int msb);
        logic [31:0] hi;
        hi = $signed(v) >>> msb;
        return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
    endfunction

    always_comb begin
        enc_word = 32'h0;
        enc_ok   = 1'b1;
        case (op_q)
            5'd0:  enc_word = 32'h8B00_0000 | {11'b0, rm_q, 6'b0, rn_q, rd_q};
            5'd1:  enc_word = 32'hAB00_0000 | {11'b0, rm_q, 6'b0, rn_q, rd_q};
            5'd2:  enc_word = 32'hCB00_0000 | {11'b0, rm_q, 6'b0, rn_q, rd_q};
            5'd3:  enc_word = 32'hEB00_0000 | {11'b0, rm_q, 6'b0, rn_q, rd_q};
            5'd4:  enc_word = 32'h8A00_0000 | {11'b0, rm_q, 6'b0, rn_q, rd_q};
            5'd5:  enc_word = 32'hAA00_0000 | {11'b0, rm_q, 6'b0, rn_q, rd_q};
            5'd6:  enc_word = 32'hCA00_0000 | {11'b0, rm_q, 6'b0, rn_q, rd_q};
            5'd7:  enc_word = 32'hEA00_0000 | {11'b0, rm_q, 6'b0, rn_q, rd_q};
            5'd8, 5'd9, 5'd10, 5'd11: begin
                enc_ok = (imm_q[31:12] == 20'h0);
                case (op_q[1:0])
                    2'd0:    enc_word = 32'h9100_0000;
                    2'd1:    enc_word = 32'hB100_0000;
                    2'd2:    enc_word = 32'hD100_0000;
                    default: enc_word = 32'hF100_0000;
                endcase
                enc_word = enc_word | {10'b0, imm_q[11:0], rn_q, rd_q};
            end
            5'd12, 5'd13: begin
                enc_ok   = (imm_q[31:16] == 16'h0);
                enc_word = (op_q[0] ? 32'hF280_0000 : 32'hD280_0000)
                         | {9'b0, hw_q, imm_q[15:0], rd_q};
            end
            5'd14, 5'd15: begin
                enc_ok   = fits_signed(imm_q, 25);
                enc_word = (op_q[0] ? 32'h9400_0000 : 32'h1400_0000) | {6'b0, imm_q[25:0]};
            end
            5'd16, 5'd17: begin
                enc_ok   = fits_signed(imm_q, 18);
                enc_word = (op_q[0] ? 32'hB500_0000 : 32'hB400_0000) | {8'b0, imm_q[18:0], rd_q};
            end
            5'd18: begin
                enc_ok   = fits_signed(imm_q, 18);
                enc_word = 32'h5400_0000 | {8'b0, imm_q[18:0], 1'b0, rd_q[3:0]};
            end
            5'd19: enc_word = 32'hD61F_0000 | {22'b0, rn_q, 5'b0};
            5'd20, 5'd21: begin
                enc_ok   = fits_signed(imm_q, 8);
                enc_word = (op_q[0] ? 32'hF800_0000 : 32'hF840_0000)
                         | {11'b0, imm_q[8:0], 2'b0, rn_q, rd_q};
            end
            default: enc_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ENC;
            end
            ENC: begin
                err     = !enc_ok;
                state_d = enc_ok ? WRITE : IDLE;
            end
            WRITE: if (mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q      <= '0;
            rd_q      <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            imm_q     <= '0;
            hw_q      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_W'(BASE_ADDR);
            mem_wdata <= '0;
            instr_cnt <= '0;
        end else begin
            if (state_q == IDLE) begin
                // A same-cycle load lands first, so the accepted request writes to addr_in.
                if (addr_load) mem_addr <= addr_in;
                if (req_valid) begin
                    op_q  <= req_op;
                    rd_q  <= req_rd;
                    rn_q  <= req_rn;
                    rm_q  <= req_rm;
                    imm_q <= req_imm;
                    hw_q  <= req_hw;
                end
            end
            if (state_q == ENC && enc_ok) begin
                mem_wdata <= enc_word;
                mem_we    <= 1'b1;
            end
            if (state_q == WRITE && mem_ack) begin
                mem_we    <= 1'b0;
                mem_addr  <= mem_addr + 1'b1;
                instr_cnt <= instr_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Scoreboard bench for legv8_instr_encoder: the driver queues expected writes/errors,
// a monitor pops and compares them whenever the DUT raises mem_we or err.
module tb_legv8_instr_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        addr_load = 1'b0;
    logic [7:0]  addr_in = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0, req_rd = '0, req_rn = '0, req_rm = '0;
    logic [31:0] req_imm = '0;
    logic [1:0]  req_hw = '0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        err;
    logic [15:0] instr_cnt;

    legv8_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clock(clock), .reset(reset), .addr_load(addr_load), .addr_in(addr_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
        .req_rn(req_rn), .req_rm(req_rm), .req_imm(req_imm), .req_hw(req_hw),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .err(err), .instr_cnt(instr_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_err;
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    time         acc_t   = 0;
    logic [7:0]  m_addr  = 8'd0;
    logic [15:0] m_cnt   = 16'd0;
    bit          prev_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && (err || (mem_we && !prev_we))) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {30'b0, err, mem_we}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_kind_err", {31'b0, err}, {31'b0, e.is_err});
                    if (!err) begin
                        chk("mem_addr", {24'b0, mem_addr}, {24'b0, e.addr});
                        chk("mem_wdata", mem_wdata, e.data);
                        chk("we_latency", 32'($time - acc_t), 32'd15);
                    end else begin
                        chk("err_latency", 32'($time - acc_t), 32'd5);
                    end
                end
            end
            prev_we = mem_we;
        end
    end

    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [31:0] imm, input logic [1:0] hw,
                        input bit bad, input logic [31:0] exp_w, input bit ld,
                        input logic [7:0] ld_a);
        int k;
        @(negedge clock);
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clock); k++; end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
        if (ld) begin addr_load = 1'b1; addr_in = ld_a; m_addr = ld_a; end
        exp_q.push_back('{bad, m_addr, exp_w});
        req_op = op; req_rd = rd; req_rn = rn; req_rm = rm; req_imm = imm; req_hw = hw;
        req_valid = 1'b1;
        @(posedge clock);
        acc_t = $time;
        @(negedge clock);
        req_valid = 1'b0; addr_load = 1'b0; addr_in = 8'h5A;
        req_imm = $urandom; req_rd = 5'(k + 7);
    endtask

    task automatic wait_we();
        int k;
        k = 0;
        while (!mem_we && k < 4) begin @(negedge clock); k++; end
        chk("we_seen", {31'b0, mem_we}, 32'd1);
    endtask

    task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [31:0] imm, input logic [1:0] hw,
                         input bit bad, input logic [31:0] exp_w, input int ack_dly,
                         input bit ld, input logic [7:0] ld_a);
        int k;
        send(op, rd, rn, rm, imm, hw, bad, exp_w, ld, ld_a);
        if (bad) begin
            k = 0;
            while (!err && k < 4) begin @(negedge clock); k++; end
            chk("err_seen", {31'b0, err}, 32'd1);
            @(negedge clock);
            chk("err_one_cycle", {31'b0, err}, 32'd0);
            chk("no_we_on_err", {31'b0, mem_we}, 32'd0);
            chk("addr_hold_err", {24'b0, mem_addr}, {24'b0, m_addr});
        end else begin
            wait_we();
            for (int d = 0; d < ack_dly; d++) begin
                req_valid = 1'b1; req_op = 5'd0;
                @(negedge clock);
                chk("hold_we", {31'b0, mem_we}, 32'd1);
                chk("hold_addr", {24'b0, mem_addr}, {24'b0, m_addr});
                chk("hold_data", mem_wdata, exp_w);
                chk("ready_low", {31'b0, req_ready}, 32'd0);
            end
            req_valid = 1'b0;
            mem_ack = 1'b1;
            @(negedge clock);
            mem_ack = 1'b0;
            m_addr = m_addr + 8'd1;
            m_cnt  = m_cnt + 16'd1;
            chk("we_drop", {31'b0, mem_we}, 32'd0);
            chk("addr_inc", {24'b0, mem_addr}, {24'b0, m_addr});
            chk("instr_cnt", {16'b0, instr_cnt}, {16'b0, m_cnt});
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        #12;
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", {24'b0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_cnt", {16'b0, instr_cnt}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;

        issue(5'd0,  5'd1,  5'd2,  5'd3,  32'd0,        2'd0, 0, 32'h8B03_0041, 0, 0, 8'd0);
        issue(5'd8,  5'd0,  5'd0,  5'd0,  32'd4095,     2'd0, 0, 32'h913F_FC00, 0, 0, 8'd0);
        issue(5'd8,  5'd0,  5'd0,  5'd0,  32'd4096,     2'd0, 1, 32'h0,         0, 0, 8'd0);
        issue(5'd14, 5'd0,  5'd0,  5'd0,  32'hFFFF_FFFF, 2'd0, 0, 32'h17FF_FFFF, 0, 0, 8'd0);
        issue(5'd20, 5'd5,  5'd6,  5'd0,  -32'sd8,      2'd0, 0, 32'hF85F_80C5, 3, 0, 8'd0);
        issue(5'd25, 5'd1,  5'd2,  5'd3,  32'd0,        2'd0, 1, 32'h0,         0, 0, 8'd0);
        issue(5'd3,  5'd31, 5'd30, 5'd29, 32'h1234,     2'd2, 0, 32'hEB1D_03DF, 1, 0, 8'd0);
        issue(5'd13, 5'd7,  5'd9,  5'd9,  32'hFFFF,     2'd3, 0, 32'hF2FF_FFE7, 0, 0, 8'd0);
        issue(5'd12, 5'd7,  5'd0,  5'd0,  32'h1_0000,   2'd0, 1, 32'h0,         0, 0, 8'd0);
        issue(5'd16, 5'd3,  5'd8,  5'd8,  -32'sd262144, 2'd0, 0, 32'hB480_0003, 0, 0, 8'd0);
        issue(5'd17, 5'd3,  5'd0,  5'd0,  32'd262144,   2'd0, 1, 32'h0,         0, 0, 8'd0);
        issue(5'd18, 5'h11, 5'd4,  5'd4,  32'd4,        2'd0, 0, 32'h5400_0081, 0, 0, 8'd0);
        issue(5'd19, 5'd9,  5'd30, 5'd9,  32'd77,       2'd0, 0, 32'hD61F_03C0, 0, 0, 8'd0);
        issue(5'd21, 5'd1,  5'd2,  5'd0,  32'd255,      2'd0, 0, 32'hF80F_F041, 0, 0, 8'd0);
        issue(5'd20, 5'd1,  5'd2,  5'd0,  -32'sd257,    2'd0, 1, 32'h0,         0, 0, 8'd0);
        issue(5'd14, 5'd0,  5'd0,  5'd0,  32'h01FF_FFFF, 2'd0, 0, 32'h15FF_FFFF, 0, 0, 8'd0);
        issue(5'd15, 5'd0,  5'd0,  5'd0,  -32'sd33554432, 2'd0, 0, 32'h9600_0000, 0, 0, 8'd0);
        issue(5'd10, 5'd4,  5'd5,  5'd9,  32'd0,        2'd0, 0, 32'hD100_00A4, 0, 0, 8'd0);
        issue(5'd5,  5'd1,  5'd1,  5'd1,  32'hDEAD,     2'd1, 0, 32'hAA01_0021, 0, 0, 8'd0);

        // reset while a write is pending: the write is dropped
        send(5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0, 0, 32'h8B03_0041, 0, 8'd0);
        wait_we();
        #2 reset = 1'b0;
        #1;
        chk("midrst_we", {31'b0, mem_we}, 32'd0);
        chk("midrst_addr", {24'b0, mem_addr}, 32'd0);
        chk("midrst_cnt", {16'b0, instr_cnt}, 32'd0);
        m_addr = 8'd0;
        m_cnt  = 16'd0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_we", {31'b0, mem_we}, 32'd0);

        // address load with a same-cycle request, then wrap from 255 to 0
        issue(5'd12, 5'd2, 5'd0, 5'd0, 32'd1, 2'd1, 0, 32'hD2A0_0022, 0, 1, 8'd255);
        issue(5'd12, 5'd2, 5'd0, 5'd0, 32'd1, 2'd1, 0, 32'hD2A0_0022, 0, 0, 8'd0);
        chk("final_cnt", {16'b0, instr_cnt}, 32'd2);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
